// File: rtl/modadd_arb.sv
// Round-robin arbiter feeding one shared modular adder (A+B) mod MOD, 1-cycle latency.
// Optional lock feature enabled by defining MODADD_ARB_LOCK_EN.
module modadd_arb #(
   parameter int                MWIDTH = 39,
   parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001,
   parameter int                NREQ   = 4,
   parameter int                IDW    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_hold,
   input  logic [NREQ-1:0]          i_req_vld,
   output logic [NREQ-1:0]          o_req_rdy,
   input  logic [NREQ*MWIDTH-1:0]   i_req_din_0,
   input  logic [NREQ*MWIDTH-1:0]   i_req_din_1,
`ifdef MODADD_ARB_LOCK_EN
   input  logic [NREQ-1:0]          i_req_lock,
`endif
   output logic [NREQ-1:0]          o_rsp_vld,
   output logic [IDW-1:0]           o_rsp_id,
   output logic [MWIDTH-1:0]        o_rsp_dout,
   output logic                     o_busy
);

   logic [IDW-1:0]    rr_ptr_r;
   logic [NREQ-1:0]   rsp_vld_r;
   logic [IDW-1:0]    rsp_id_r;
   logic [MWIDTH-1:0] rsp_dout_r;

   logic [NREQ-1:0]   gnt_s;
   logic [IDW-1:0]    gnt_idx_s;
   logic              gnt_any_s;
   logic [MWIDTH-1:0] opa_s;
   logic [MWIDTH-1:0] opb_s;
   logic [MWIDTH:0]   sum_s;
   logic [MWIDTH-1:0] res_s;

`ifdef MODADD_ARB_LOCK_EN
   logic              lock_vld_r;
   logic [IDW-1:0]    lock_own_r;
`endif

   // Index base+off wrapped into 0..NREQ-1 (off never exceeds NREQ-1).
   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
      int sum_v;
      sum_v = int'(base) + off;
      if (sum_v >= NREQ) begin
         return IDW'(sum_v - NREQ);
      end else begin
         return IDW'(sum_v);
      end
   endfunction

   // Grant selection: hold blocks everything, a lock pins the owner, otherwise round-robin from rr_ptr.
   always_comb begin
      logic [IDW-1:0] idx_v;
      gnt_s     = '0;
      gnt_idx_s = '0;
      gnt_any_s = 1'b0;
      idx_v     = '0;
      if (i_hold) begin
         gnt_any_s = 1'b0;
      end
`ifdef MODADD_ARB_LOCK_EN
      else if (lock_vld_r) begin
         if (i_req_vld[lock_own_r]) begin
            gnt_s[lock_own_r] = 1'b1;
            gnt_idx_s         = lock_own_r;
            gnt_any_s         = 1'b1;
         end else begin
            gnt_any_s = 1'b0;
         end
      end
`endif
      else begin
         for (int i = 0; i < NREQ; i++) begin
            idx_v = wrap_idx(rr_ptr_r, i);
            if (!gnt_any_s && i_req_vld[idx_v]) begin
               gnt_s[idx_v] = 1'b1;
               gnt_idx_s    = idx_v;
               gnt_any_s    = 1'b1;
            end else begin
               gnt_any_s = gnt_any_s;
            end
         end
      end
   end

   // Shared modular adder on the granted operand pair; one conditional subtract suffices for in-range operands.
   always_comb begin
      opa_s = i_req_din_0[gnt_idx_s*MWIDTH +: MWIDTH];
      opb_s = i_req_din_1[gnt_idx_s*MWIDTH +: MWIDTH];
      sum_s = {1'b0, opa_s} + {1'b0, opb_s};
      if (sum_s >= {1'b0, MOD}) begin
         res_s = MWIDTH'(sum_s - {1'b0, MOD});
      end else begin
         res_s = sum_s[MWIDTH-1:0];
      end
   end

   // Response register, round-robin pointer and lock state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r   <= '0;
         rsp_vld_r  <= '0;
         rsp_id_r   <= '0;
         rsp_dout_r <= '0;
`ifdef MODADD_ARB_LOCK_EN
         lock_vld_r <= 1'b0;
         lock_own_r <= '0;
`endif
      end else begin
         rsp_vld_r <= gnt_s;
         if (gnt_any_s) begin
            rsp_id_r   <= gnt_idx_s;
            rsp_dout_r <= res_s;
            rr_ptr_r   <= wrap_idx(gnt_idx_s, 1);
         end else begin
            rsp_id_r   <= '0;
            rsp_dout_r <= '0;
         end
`ifdef MODADD_ARB_LOCK_EN
         if (lock_vld_r) begin
            if (gnt_any_s && !i_req_lock[lock_own_r]) begin
               lock_vld_r <= 1'b0;
            end else if (!i_hold && !i_req_vld[lock_own_r]) begin
               lock_vld_r <= 1'b0;
               rr_ptr_r   <= wrap_idx(lock_own_r, 1);
            end
         end else if (gnt_any_s && i_req_lock[gnt_idx_s]) begin
            lock_vld_r <= 1'b1;
            lock_own_r <= gnt_idx_s;
         end
`endif
      end
   end

   assign o_req_rdy  = gnt_s;
   assign o_rsp_vld  = rsp_vld_r;
   assign o_rsp_id   = rsp_id_r;
   assign o_rsp_dout = rsp_dout_r;
   assign o_busy     = (|i_req_vld) | (|rsp_vld_r);

endmodule

// File: tb/tb_modadd_arb.sv
// Directed bench for modadd_arb: single transfers, modular wrap, round-robin order, hold, reset, lock.
module tb_modadd_arb;

   localparam int              MW   = 39;
   localparam int              NREQ = 4;
   localparam int              IDW  = 2;
   localparam logic [MW-1:0]   MOD  = 39'h40_0080_0001;
   localparam logic [MW-1:0]   MODM1 = 39'h40_0080_0000;

   logic                 clk;
   logic                 rst_n;
   logic                 i_hold;
   logic [NREQ-1:0]      i_req_vld;
   logic [NREQ-1:0]      o_req_rdy;
   logic [NREQ*MW-1:0]   i_req_din_0;
   logic [NREQ*MW-1:0]   i_req_din_1;
   logic [NREQ-1:0]      i_req_lock;
   logic [NREQ-1:0]      o_rsp_vld;
   logic [IDW-1:0]       o_rsp_id;
   logic [MW-1:0]        o_rsp_dout;
   logic                 o_busy;

   int n_checks = 0;
   int n_errors = 0;

   modadd_arb #(.MWIDTH(MW), .MOD(MOD), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_hold      (i_hold),
      .i_req_vld   (i_req_vld),
      .o_req_rdy   (o_req_rdy),
      .i_req_din_0 (i_req_din_0),
      .i_req_din_1 (i_req_din_1),
`ifdef MODADD_ARB_LOCK_EN
      .i_req_lock  (i_req_lock),
`endif
      .o_rsp_vld   (o_rsp_vld),
      .o_rsp_id    (o_rsp_id),
      .o_rsp_dout  (o_rsp_dout),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [MW-1:0] a, input logic [MW-1:0] b);
      i_req_din_0[k*MW +: MW] = a;
      i_req_din_1[k*MW +: MW] = b;
   endtask

   task automatic check_rsp(input string tag, input logic [NREQ-1:0] vld, input logic [IDW-1:0] id,
                            input logic [MW-1:0] dout);
      check_eq({tag, "_vld"}, 64'(o_rsp_vld), 64'(vld));
      check_eq({tag, "_id"}, 64'(o_rsp_id), 64'(id));
      check_eq({tag, "_dout"}, 64'(o_rsp_dout), 64'(dout));
   endtask

   initial begin
      rst_n       = 1'b0;
      i_hold      = 1'b0;
      i_req_vld   = '0;
      i_req_din_0 = '0;
      i_req_din_1 = '0;
      i_req_lock  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_rsp("reset", 4'b0000, 2'd0, 39'd0);
      check_eq("reset_rdy", 64'(o_req_rdy), 64'd0);
      check_eq("reset_busy", 64'(o_busy), 64'd0);
      rst_n = 1'b1;

      // single request on req0 that wraps to 1
      set_req(0, MODM1, 39'd2);
      i_req_vld = 4'b0001;
      #1;
      check_eq("single_rdy", 64'(o_req_rdy), 64'b0001);
      check_eq("single_busy", 64'(o_busy), 64'd1);
      tick();
      i_req_vld = 4'b0000;
      #1;
      check_rsp("single", 4'b0001, 2'd0, 39'd1);

      // req2 without wrap: 5+7
      set_req(2, 39'd5, 39'd7);
      i_req_vld = 4'b0100;
      #1;
      check_eq("nowrap_rdy", 64'(o_req_rdy), 64'b0100);
      tick();
      i_req_vld = 4'b0000;
      #1;
      check_rsp("nowrap", 4'b0100, 2'd2, 39'd12);

      // largest legal operands on req3: 2*(MOD-1) mod MOD = MOD-2
      set_req(3, MODM1, MODM1);
      i_req_vld = 4'b1000;
      #1;
      check_eq("maxop_rdy", 64'(o_req_rdy), 64'b1000);
      tick();
      i_req_vld = 4'b0000;
      #1;
      check_rsp("maxop", 4'b1000, 2'd3, 39'h40_007F_FFFF);

      // idle cycle: outputs return to zero
      tick();
      #1;
      check_rsp("idle", 4'b0000, 2'd0, 39'd0);
      check_eq("idle_busy", 64'(o_busy), 64'd0);

      // round-robin from reset, each pair (k+1)+(MOD-1) gives k
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < NREQ; k++) set_req(k, MW'(k + 1), MODM1);
      i_req_vld = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         check_eq($sformatf("rr_rdy_%0d", c), 64'(o_req_rdy), 64'(1 << (c % 4)));
         if (c > 0) check_rsp($sformatf("rr_rsp_%0d", c), 4'(1 << ((c - 1) % 4)),
                              2'((c - 1) % 4), 39'((c - 1) % 4));
         else check_rsp("rr_rsp_0", 4'b0000, 2'd0, 39'd0);
         tick();
      end
      #1;
      check_eq("rr_rdy_8", 64'(o_req_rdy), 64'b0001);
      check_rsp("rr_rsp_8", 4'b1000, 2'd3, 39'd3);
      tick();

      // hold for 3 cycles with rr_ptr at 1; in-flight result still completes
      i_hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         #1;
         check_eq($sformatf("hold_rdy_%0d", h), 64'(o_req_rdy), 64'd0);
         check_eq($sformatf("hold_busy_%0d", h), 64'(o_busy), 64'd1);
         if (h == 0) check_rsp("hold_rsp_0", 4'b0001, 2'd0, 39'd0);
         else check_eq($sformatf("hold_rsp_vld_%0d", h), 64'(o_rsp_vld), 64'd0);
         tick();
      end
      i_hold = 1'b0;
      #1;
      check_eq("unhold_rdy", 64'(o_req_rdy), 64'b0010);

      // reset right after a grant to req1 discards the result
      i_req_vld = 4'b0010;
      tick();
      rst_n = 1'b0;
      #1;
      check_rsp("rstflight", 4'b0000, 2'd0, 39'd0);
      tick();
      rst_n = 1'b1;
      i_req_vld = 4'b1111;
      #1;
      check_eq("postrst_rdy", 64'(o_req_rdy), 64'b0001);
      check_eq("postrst_vld", 64'(o_rsp_vld), 64'd0);
      tick();
      #1;
      check_rsp("postrst_rsp", 4'b0001, 2'd0, 39'd0);
      i_req_vld = 4'b0000;

`ifdef MODADD_ARB_LOCK_EN
      // req1 holds a lock over 3 transfers with everyone valid
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      i_req_vld = 4'b0001;
      tick();
      i_req_vld  = 4'b1111;
      i_req_lock = 4'b0010;
      #1;
      check_eq("lock_rdy_0", 64'(o_req_rdy), 64'b0010);
      tick();
      #1;
      check_eq("lock_rdy_1", 64'(o_req_rdy), 64'b0010);
      check_eq("lock_id_0", 64'(o_rsp_id), 64'd1);
      tick();
      i_req_lock = 4'b0000;
      #1;
      check_eq("lock_rdy_2", 64'(o_req_rdy), 64'b0010);
      tick();
      #1;
      check_eq("lock_rel_rdy", 64'(o_req_rdy), 64'b0100);
      check_eq("lock_id_2", 64'(o_rsp_id), 64'd1);
      i_req_vld = 4'b0000;
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/modadd_arb.md
MODADD_ARB -- requirements
Module: modadd_arb

Interface
REQ-001 Parameter MOD, default 39'h40_0080_0001: modulus applied to every sum.
REQ-002 Parameter MWIDTH, default 39: operand and result width.
REQ-003 Parameter NREQ, default 4: requester count, range 2..16.
REQ-004 Parameter IDW, default 2: response id width, equal to clog2(NREQ).
REQ-005 clk  input  1: single clock, all logic on its rising edge.
REQ-006 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 i_hold  input  1: when high, no grant is issued.
REQ-008 i_req_vld  input  NREQ: per-requester operand-pair valid.
REQ-009 o_req_rdy  output  NREQ: one-hot or zero grant; transfer occurs when vld and rdy are both high.
REQ-010 i_req_din_0  input  NREQ*MWIDTH: operand A; requester k occupies bits [k*MWIDTH +: MWIDTH].
REQ-011 i_req_din_1  input  NREQ*MWIDTH: operand B, same packing as operand A.
REQ-012 i_req_lock  input  NREQ: lock request per requester; present only with MODADD_ARB_LOCK_EN.
REQ-013 o_rsp_vld  output  NREQ: registered one-hot result strobe.
REQ-014 o_rsp_id  output  IDW: binary index of the requester that owns the result.
REQ-015 o_rsp_dout  output  MWIDTH: (A+B) mod MOD.
REQ-016 o_busy  output  1: high when any requester is valid or a result is in flight.

Function
REQ-017 Grant is combinational from i_req_vld, i_hold, rr_ptr and the lock state; at most one bit is granted per cycle.
REQ-018 Round-robin: search starts at index rr_ptr and proceeds upward with wrap; the first valid requester wins.
REQ-019 After a grant to k, rr_ptr becomes (k+1) mod NREQ; with no grant, rr_ptr holds.
REQ-020 The granted operands drive one shared internal modular adder (sum width MWIDTH+1; subtract MOD when sum >= MOD). The adder's valid is the OR of all grants.
REQ-021 Latency is exactly 1 cycle: a transfer in cycle t gives o_rsp_vld[k]=1, o_rsp_id=k and o_rsp_dout valid in cycle t+1. There is no response backpressure.
REQ-022 Back-to-back grants are supported at 1 result per cycle.
REQ-023 When no result is in flight, o_rsp_vld=0, o_rsp_id=0 and o_rsp_dout=0.
REQ-024 Keeping operands below MOD is a requester obligation; the result for operands >= MOD is unspecified, but must not corrupt arbitration.
REQ-025 i_hold=1 forces o_req_rdy=0. A result already in flight still completes the next cycle.
REQ-026 o_req_rdy[k] may be high while i_req_vld[k]=0 never; rdy is asserted only for a valid requester.
REQ-027 Requester vld/operands must stay stable until granted; dropping vld before a grant is permitted and drops that request silently.

Reset
REQ-028 rst_n low clears rr_ptr=0, o_rsp_vld=0, o_rsp_id=0, o_rsp_dout=0, lock owner and lock-valid, asynchronously.
REQ-029 A result in flight when reset asserts is discarded; no strobe appears after reset release.
REQ-030 In the first cycle after release, the lowest valid index is granted.

Configuration
REQ-031 Macro MODADD_ARB_LOCK_EN defined: a transfer from k with i_req_lock[k]=1 sets lock owner=k. While locked, only k may be granted, regardless of rr_ptr.
REQ-032 Lock release occurs on a granted transfer from the owner with i_req_lock=0, or in a cycle where the owner's vld=0. On release, rr_ptr=(owner+1) mod NREQ.
REQ-033 i_hold overrides lock: no grant is issued, and the lock is retained.
REQ-034 Macro undefined: port i_req_lock and all lock logic are absent; arbitration is pure round-robin.

Verification
REQ-035 Single request: req0 with A=39'h40_0080_0000, B=2 -> next cycle o_rsp_vld=4'b0001, id=0, dout=1.
REQ-036 No wrap: req2 with A=5, B=7 -> dout=12, id=2, 1-cycle latency.
REQ-037 All four requesters valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3 with one result per cycle.
REQ-038 i_hold=1 for 3 cycles with all requesters valid -> o_req_rdy=0 for those 3 cycles, rr_ptr unchanged, o_busy=1.
REQ-039 rst_n pulsed low the cycle after a grant to req1 -> no o_rsp_vld afterwards; the next grant goes to req0.
REQ-040 With LOCK_EN: req1 locks for 3 transfers while req0/2/3 are valid -> grants 1,1,1; after release the next grant is 2.
